// File: rtl/nn_pkg.sv
// Shared definitions for the layer-2 neuron logic and its argmax stage.
// Holds the classifier FSM encoding and the default class count.
package nn_pkg;

  localparam int NN_NUM_CLASSES = 10;
  localparam int NN_IDX_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } l2_state_e;

endpackage

// File: rtl/l2_argmax.sv
// Scans the layer-2 neuron results of one frame and reports the argmax.
// Strictly-greater compare, so ties keep the lower neuron index.
module l2_argmax
  import nn_pkg::*;
#(
  parameter int NUM_CLASSES = NN_NUM_CLASSES,
  parameter int DW          = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  output logic [NN_IDX_W-1:0] neuron_sel,
  output logic                busy,
  output logic                class_valid,
  input  logic                class_ready,
  output logic [NN_IDX_W-1:0] class_id,
  output logic [DW-1:0]       class_score,
  output logic                stray
);

  localparam logic [NN_IDX_W-1:0] LAST =
    NN_IDX_W'(NUM_CLASSES - 1);
  localparam logic [DW-1:0] MIN_SCORE =
    {1'b1, {(DW-1){1'b0}}};

  l2_state_e state_q, state_d;

  logic [NN_IDX_W-1:0] idx_q, idx_d;
  logic [NN_IDX_W-1:0] best_id_q, best_id_d;
  logic [DW-1:0]       best_score_q, best_score_d;
  logic [NN_IDX_W-1:0] class_id_q, class_id_d;
  logic [DW-1:0]       class_score_q, class_score_d;
  logic                stray_q, stray_d;
  logic                better;

  assign better = $signed(in_data) > $signed(best_score_q);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    best_id_d     = best_id_q;
    best_score_d  = best_score_q;
    class_id_d    = class_id_q;
    class_score_d = class_score_q;
    stray_d       = stray_q;

    if (in_valid && state_q != ST_COLLECT) begin
      stray_d = 1'b1;
    end

    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (start) begin
          state_d      = ST_COLLECT;
          idx_d        = '0;
          best_id_d    = '0;
          best_score_d = MIN_SCORE;
        end
      end
      (state_q == ST_COLLECT): begin
        if (in_valid) begin
          if (better) begin
            best_id_d    = idx_q;
            best_score_d = in_data;
          end
          if (idx_q == LAST) begin
            // Final compare feeds the result registers directly.
            state_d       = ST_DONE;
            class_id_d    = better ? idx_q : best_id_q;
            class_score_d = better ? in_data : best_score_q;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      (state_q == ST_DONE): begin
        if (class_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      best_id_q     <= '0;
      best_score_q  <= MIN_SCORE;
      class_id_q    <= '0;
      class_score_q <= '0;
      stray_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      best_id_q     <= best_id_d;
      best_score_q  <= best_score_d;
      class_id_q    <= class_id_d;
      class_score_q <= class_score_d;
      stray_q       <= stray_d;
    end
  end

  assign neuron_sel  = (state_q == ST_COLLECT) ? idx_q : '0;
  assign busy        = (state_q != ST_IDLE);
  assign class_valid = (state_q == ST_DONE);
  assign class_id    = class_id_q;
  assign class_score = class_score_q;
  assign stray       = stray_q;

endmodule

// File: tb/tb_l2_argmax.sv
// Randomized and directed frames for l2_argmax.
// Expected results come from a plain argmax over the frame array.
module tb_l2_argmax;

  localparam int N = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic [3:0] neuron_sel;
  logic       busy;
  logic       class_valid;
  logic       class_ready;
  logic [3:0] class_id;
  logic [7:0] class_score;
  logic       stray;

  int n_tests = 0;
  int n_fail  = 0;

  int sc[N];

  l2_argmax dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .neuron_sel (neuron_sel),
    .busy       (busy),
    .class_valid(class_valid),
    .class_ready(class_ready),
    .class_id   (class_id),
    .class_score(class_score),
    .stray      (stray)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: signed argmax, first maximum wins.
  task automatic ref_argmax(output int id, output int val);
    id  = 0;
    val = sc[0];
    for (int i = 1; i < N; i++) begin
      if (sc[i] > val) begin
        val = sc[i];
        id  = i;
      end
    end
  endtask

  task automatic run_frame(input int gap,
                           input int hold,
                           input bit mid_start);
    int eid, eval;
    logic [7:0] ev;
    ref_argmax(eid, eval);
    ev = eval[7:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < N; i++) begin
      for (int g = 0; g < gap; g++) begin
        tick();
        check("gap_busy", busy, 1);
        check("gap_sel", neuron_sel, i);
      end
      check("neuron_sel", neuron_sel, i);
      check("no_early_valid", class_valid, 0);
      in_valid = 1'b1;
      in_data  = sc[i][7:0];
      start    = mid_start && (i == 5);
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
    end
    check("class_valid", class_valid, 1);
    check("class_id", class_id, eid);
    check("class_score", class_score, ev);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", class_valid, 1);
      check("hold_busy", busy, 1);
      check("hold_id", class_id, eid);
      check("hold_score", class_score, ev);
      check("done_sel", neuron_sel, 0);
    end
    class_ready = 1'b1;
    start       = 1'b1;
    tick();
    class_ready = 1'b0;
    start       = 1'b0;
    check("valid_drop", class_valid, 0);
    check("idle_busy", busy, 0);
    check("keep_id", class_id, eid);
    check("keep_score", class_score, ev);
    tick();
    check("no_restart", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    class_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_valid", class_valid, 0);
    check("rst_id", class_id, 0);
    check("rst_score", class_score, 0);
    check("rst_stray", stray, 0);
    check("rst_sel", neuron_sel, 0);

    // Ascending values.
    for (int i = 0; i < N; i++) sc[i] = i;
    run_frame(0, 0, 1'b0);

    // Negatives and ties.
    sc = '{-5, -3, -3, -128, -100, -7, -3, -50, -4, -9};
    run_frame(0, 0, 1'b0);

    // All at the most negative value.
    for (int i = 0; i < N; i++) sc[i] = -128;
    run_frame(0, 1, 1'b0);

    // Gapped strobes with backpressure.
    for (int i = 0; i < N; i++) sc[i] = 20 - 3 * i;
    sc[7] = 40;
    run_frame(3, 5, 1'b0);

    // Stray strobe in IDLE, then a frame with start mid-collect.
    in_valid = 1'b1;
    in_data  = 8'd127;
    tick();
    in_valid = 1'b0;
    check("stray_set", stray, 1);
    check("stray_idle", busy, 0);
    for (int i = 0; i < N; i++) sc[i] = 10 + i;
    sc[2] = 100;
    run_frame(0, 0, 1'b1);
    check("stray_sticky", stray, 1);

    // Reset mid-frame.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'd90;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", class_valid, 0);
    check("mid_rst_id", class_id, 0);
    check("mid_rst_score", class_score, 0);
    check("mid_rst_stray", stray, 0);
    check("mid_rst_sel", neuron_sel, 0);
    for (int i = 0; i < N; i++) sc[i] = 50 - i;
    sc[8] = 60;
    run_frame(0, 0, 1'b0);

    // Randomized frames, some with forced ties.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < N; i++) begin
        sc[i] = int'($urandom_range(0, 255)) - 128;
      end
      if (f % 2 == 0) begin
        sc[$urandom_range(5, 9)] = sc[$urandom_range(0, 4)];
      end
      run_frame(int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
